// File: rtl/mem_byte_lsu_pkg.sv
// mem_byte_lsu_pkg
// Shared types and helpers for the byte-serial data-side load/store unit.
//   state_t        : controller states (IDLE, LOAD, LOAD_TAIL, STORE)
//   BYTES_PER_WORD : byte beats in one word access
//   byte_lane()    : big-endian lane select, lane i = bits [31-8i -: 8]
package mem_byte_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        LOAD_TAIL = 2'd2,
        STORE     = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] result;
        case (lane)
            2'd0:    result = word[31:24];
            2'd1:    result = word[23:16];
            2'd2:    result = word[15:8];
            default: result = word[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_byte_lsu_if.sv
// mem_byte_lsu_if
// Request/response and byte-wide memory signals of the load/store unit.
//   req_valid/req_ready/req_we/req_addr/req_wdata : word request from the core
//   req_byte                                       : single-byte access (only when
//                                                    MEM_BYTE_LSU_BYTE_ACCESS_EN is defined)
//   resp_valid/resp_rdata                          : completion pulse and load result
//   mem_rw_addr/mem_w/mem_w_en/mem_r               : byte-wide memory port
// Modports: slave = the LSU, master = core plus memory (the environment).
interface mem_byte_lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
    logic              req_byte;
`endif
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_rw_addr;
    logic [7:0]        mem_w;
    logic              mem_w_en;
    logic [7:0]        mem_r;

    modport slave (
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
        input  req_byte,
`endif
        input  req_valid, req_we, req_addr, req_wdata, mem_r,
        output req_ready, resp_valid, resp_rdata, mem_rw_addr, mem_w, mem_w_en
    );

    modport master (
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
        output req_byte,
`endif
        output req_valid, req_we, req_addr, req_wdata, mem_r,
        input  req_ready, resp_valid, resp_rdata, mem_rw_addr, mem_w, mem_w_en
    );

endinterface

// File: rtl/mem_byte_lsu.sv
// mem_byte_lsu
// Runs 32-bit loads/stores as four byte accesses (big-endian) on a byte-wide
// memory whose read data is registered (valid one cycle after the address).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset; aborts any access in flight
//   bus   : mem_byte_lsu_if.slave (request, response and memory port)
// Build option: define MEM_BYTE_LSU_BYTE_ACCESS_EN to add req_byte single-byte
// accesses (unaligned address used as-is, load result zero-extended).
module mem_byte_lsu
    import mem_byte_lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_byte_lsu_if.slave bus
);

    state_t            state_q, state_d;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [23:0]       asm_q;      // lanes 0..2 of a load in progress
    logic [31:0]       rdata_q;
    logic              resp_valid_q;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;
    logic [7:0]        beat_wbyte;

`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
    logic              byte_q;

    assign last_beat  = (idx_q == 2'(BYTES_PER_WORD - 1)) || byte_q;
    assign beat_wbyte = byte_q ? wdata_q[7:0] : byte_lane(wdata_q, idx_q);
`else
    assign last_beat  = (idx_q == 2'(BYTES_PER_WORD - 1));
    assign beat_wbyte = byte_lane(wdata_q, idx_q);
`endif

    // Offset is OR-ed into the low bits so the beat address never carries
    // into the upper address bits (0xFC runs 0xFC..0xFF).
    assign beat_addr = {base_q[ADDR_W-1:2], base_q[1:0] | idx_q};

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments on every flop so all state
            // updates at an edge see the pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (bus.req_valid) state_d = bus.req_we ? STORE : LOAD;
            LOAD:      if (last_beat) state_d = LOAD_TAIL;
            LOAD_TAIL: state_d = IDLE;
            STORE:     if (last_beat) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory-side outputs decode only state and latched request fields, so
    // reset drops mem_w_en without waiting for a clock edge.
    always_comb begin
        bus.req_ready   = 1'b0;
        bus.mem_rw_addr = '0;
        bus.mem_w       = 8'h00;
        bus.mem_w_en    = 1'b0;
        unique case (state_q)
            IDLE:    bus.req_ready = 1'b1;
            LOAD:    bus.mem_rw_addr = beat_addr;
            STORE: begin
                bus.mem_rw_addr = beat_addr;
                bus.mem_w       = beat_wbyte;
                bus.mem_w_en    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the assembly register is reset too; it is a handful of
            // flops, not a RAM, and a known value keeps resp_rdata clean.
            idx_q        <= 2'd0;
            base_q       <= '0;
            wdata_q      <= 32'h0;
            asm_q        <= 24'h0;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
            byte_q       <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    idx_q <= 2'd0;
                    if (bus.req_valid) begin
                        wdata_q <= bus.req_wdata;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
                        byte_q  <= bus.req_byte;
                        base_q  <= bus.req_byte ? bus.req_addr
                                                : {bus.req_addr[ADDR_W-1:2], 2'b00};
`else
                        base_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
`endif
                    end
                end
                LOAD: begin
                    idx_q <= last_beat ? 2'd0 : idx_q + 2'd1;
                    // mem_r lags the address by one cycle: at beat idx it
                    // holds lane idx-1. Shifting in keeps lane 0 on top.
                    if (idx_q != 2'd0) asm_q <= {asm_q[15:0], bus.mem_r};
                end
                LOAD_TAIL: begin
                    idx_q        <= 2'd0;
                    resp_valid_q <= 1'b1;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
                    rdata_q      <= byte_q ? {24'h0, bus.mem_r} : {asm_q, bus.mem_r};
`else
                    rdata_q      <= {asm_q, bus.mem_r};
`endif
                end
                STORE: begin
                    idx_q <= last_beat ? 2'd0 : idx_q + 2'd1;
                    if (last_beat) resp_valid_q <= 1'b1;
                end
                default: idx_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_lsu.sv
// tb_mem_byte_lsu
// Self-checking bench for mem_byte_lsu: a byte-array memory with registered
// read data, a reference byte array holding the expected memory contents,
// directed scenarios and randomized traffic. Outputs are sampled on the
// falling edge; cycle N is the half-period following rising edge N.
module tb_mem_byte_lsu;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_byte_lsu_if #(.ADDR_W(8)) bus ();

    mem_byte_lsu #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External memory: byte array, write-enable strobe, registered read.
    logic [7:0] mem [256];
    logic [7:0] mem_r_q;
    logic       poke_en;
    logic [7:0] poke_addr;
    logic [7:0] poke_data;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.mem_w_en) mem[bus.mem_rw_addr] <= bus.mem_w;
        mem_r_q <= mem[bus.mem_rw_addr];
    end
    assign bus.mem_r = mem_r_q;

    logic [7:0]  ref_mem [256];
    logic [31:0] hold_rdata;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    task automatic poke_word(input logic [7:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            poke_en   = 1'b1;
            poke_addr = a + 8'(k);
            poke_data = 8'(w >> (8 * (3 - k)));
            ref_mem[a + 8'(k)] = poke_data;
        end
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic start_req(input bit we, input logic [7:0] addr, input logic [31:0] wd,
                             input bit by);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
        bus.req_byte  = by;
`else
        if (by) $display("note: byte request issued in a word-only build");
`endif
    endtask

    // Entered at a falling edge with the request already presented; the next
    // rising edge accepts it. Returns at the falling edge of the response
    // cycle; with chain set, the next request is presented in that cycle.
    task automatic run_op(input bit we, input logic [7:0] addr, input logic [31:0] wd,
                          input bit by, input bit chain, input bit nwe,
                          input logic [7:0] naddr, input logic [31:0] nwd, input bit nby,
                          input string name);
        logic [7:0]  base;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [31:0] exp;
        int          n;
        int          lat;
        int          got;
        base = by ? addr : {addr[7:2], 2'b00};
        n    = by ? 1 : 4;
        lat  = we ? n + 1 : n + 2;
        exp  = by ? {24'h0, ref_mem[base]}
                  : {ref_mem[base], ref_mem[base + 8'd1], ref_mem[base + 8'd2], ref_mem[base + 8'd3]};
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_accept got %b exp 1", name, bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = $urandom;
        got = 0;
        for (int c = 1; c <= 12 && got == 0; c++) begin
            @(negedge clk);
            if (c <= n) begin
                ea = base + 8'(c - 1);
                checks++;
                if (bus.mem_rw_addr !== ea) begin
                    errors++;
                    $display("FAIL %s addr cycle %0d got %h exp %h", name, c, bus.mem_rw_addr, ea);
                end
                checks++;
                if (bus.mem_w_en !== we) begin
                    errors++;
                    $display("FAIL %s w_en cycle %0d got %b exp %b", name, c, bus.mem_w_en, we);
                end
                if (we) begin
                    eb = by ? wd[7:0] : 8'(wd >> (8 * (4 - c)));
                    checks++;
                    if (bus.mem_w !== eb) begin
                        errors++;
                        $display("FAIL %s wbyte cycle %0d got %h exp %h", name, c, bus.mem_w, eb);
                    end
                end
            end else begin
                checks++;
                if (bus.mem_w_en !== 1'b0) begin
                    errors++;
                    $display("FAIL %s w_en_late cycle %0d got %b exp 0", name, c, bus.mem_w_en);
                end
            end
            if (bus.resp_valid === 1'b1) begin
                got = c;
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready_at_resp got %b exp 1", name, bus.req_ready);
                end
                checks++;
                if (!we) begin
                    if (bus.resp_rdata !== exp) begin
                        errors++;
                        $display("FAIL %s rdata got %h exp %h", name, bus.resp_rdata, exp);
                    end
                    hold_rdata = exp;
                end else if (bus.resp_rdata !== hold_rdata) begin
                    errors++;
                    $display("FAIL %s rdata_kept got %h exp %h", name, bus.resp_rdata, hold_rdata);
                end
                if (chain) start_req(nwe, naddr, nwd, nby);
            end
        end
        checks++;
        if (got != lat) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d (0 = no response)", name, got, lat);
        end
        if (we) begin
            if (by) ref_mem[base] = wd[7:0];
            else for (int k = 0; k < 4; k++) ref_mem[base + 8'(k)] = 8'(wd >> (8 * (3 - k)));
            checks++;
            if (by ? (mem[base] !== wd[7:0]) : (mem_word(base) !== wd)) begin
                errors++;
                $display("FAIL %s mem_after_store got %h exp %h", name, mem_word(base & 8'hFC),
                         {ref_mem[base & 8'hFC], ref_mem[(base & 8'hFC) + 8'd1],
                          ref_mem[(base & 8'hFC) + 8'd2], ref_mem[(base & 8'hFC) + 8'd3]});
            end
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        poke_en       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 32'h0;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
        bus.req_byte  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks += 6;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid got %b exp 0", bus.resp_valid); end
        if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset resp_rdata got %h exp 0", bus.resp_rdata); end
        if (bus.mem_rw_addr !== 8'h0) begin errors++; $display("FAIL reset mem_rw_addr got %h exp 0", bus.mem_rw_addr); end
        if (bus.mem_w !== 8'h0) begin errors++; $display("FAIL reset mem_w got %h exp 0", bus.mem_w); end
        if (bus.mem_w_en !== 1'b0) begin errors++; $display("FAIL reset mem_w_en got %b exp 0", bus.mem_w_en); end
        reset      = 1'b0;
        hold_rdata = 32'h0;
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            poke_en    = 1'b1;
            poke_addr  = 8'(a);
            poke_data  = 8'($urandom);
            ref_mem[a] = poke_data;
        end
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic test_word_load();
        poke_word(8'h10, 32'hDEADBEEF);
        @(negedge clk);
        start_req(1'b0, 8'h10, $urandom, 1'b0);
        run_op(1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, "load_10");
    endtask

    task automatic test_word_store();
        @(negedge clk);
        start_req(1'b1, 8'h23, 32'h12345678, 1'b0);
        run_op(1'b1, 8'h23, 32'h12345678, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, "store_23");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start_req(1'b1, 8'hFC, 32'hCAFEF00D, 1'b0);
        run_op(1'b1, 8'hFC, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 8'hFC, 32'h0, 1'b0, "b2b_store_fc");
        run_op(1'b0, 8'hFC, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, "b2b_load_fc");
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = 1'b0;
            bus.req_we    = 1'($urandom);
            bus.req_addr  = 8'($urandom);
            bus.req_wdata = $urandom;
            @(negedge clk);
            checks += 3;
            if (bus.mem_w_en !== 1'b0) begin errors++; $display("FAIL idle w_en cycle %0d got %b exp 0", c, bus.mem_w_en); end
            if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL idle resp_valid cycle %0d got %b exp 0", c, bus.resp_valid); end
            if (bus.resp_rdata !== hold_rdata) begin errors++; $display("FAIL idle rdata cycle %0d got %h exp %h", c, bus.resp_rdata, hold_rdata); end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] exp_word;
        poke_word(8'h00, 32'h0);
        @(negedge clk);
        start_req(1'b1, 8'h00, 32'hAABBCCDD, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks += 3;
        if (bus.mem_w_en !== 1'b0) begin errors++; $display("FAIL abort w_en got %b exp 0", bus.mem_w_en); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL abort resp_valid got %b exp 0", bus.resp_valid); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort req_ready got %b exp 1", bus.req_ready); end
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        hold_rdata = 32'h0;
        ref_mem[0] = 8'hAA;
        ref_mem[1] = 8'hBB;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks += 2;
            if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL abort_after resp_valid cycle %0d got %b exp 0", c, bus.resp_valid); end
            if (bus.mem_w_en !== 1'b0) begin errors++; $display("FAIL abort_after w_en cycle %0d got %b exp 0", c, bus.mem_w_en); end
        end
        exp_word = {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]};
        checks += 2;
        if (mem_word(8'h00) !== exp_word) begin errors++; $display("FAIL abort mem_word got %h exp %h", mem_word(8'h00), exp_word); end
        if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL abort rdata got %h exp 0", bus.resp_rdata); end
    endtask

    task automatic test_random();
        bit          we, nwe, by, nby, chain;
        logic [7:0]  addr, naddr;
        logic [31:0] wd, nwd;
        we   = 1'($urandom);
        addr = 8'($urandom);
        wd   = $urandom;
        by   = 1'b0;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
        by   = 1'($urandom);
`endif
        @(negedge clk);
        start_req(we, addr, wd, by);
        for (int i = 0; i < 24; i++) begin
            nwe   = 1'($urandom);
            // Bias toward a small address window so loads revisit stored words.
            naddr = 8'($urandom_range(0, 31));
            nwd   = $urandom;
            nby   = 1'b0;
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
            nby   = 1'($urandom);
`endif
            chain = (i < 23) && ($urandom_range(0, 1) == 1);
            run_op(we, addr, wd, by, chain, nwe, naddr, nwd, nby, "random");
            if (!chain && i < 23) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                start_req(nwe, naddr, nwd, nby);
            end
            we   = nwe;
            addr = naddr;
            wd   = nwd;
            by   = nby;
        end
    endtask

`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
    task automatic test_byte_access();
        poke_word(8'h10, 32'hDEADBEEF);
        @(negedge clk);
        start_req(1'b0, 8'h12, 32'h0, 1'b1);
        run_op(1'b0, 8'h12, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, "byte_load_12");
        checks++;
        if (hold_rdata !== 32'h000000BE) begin
            errors++;
            $display("FAIL byte_load_model got %h exp 000000be", hold_rdata);
        end
        @(negedge clk);
        start_req(1'b1, 8'h13, 32'h11223344, 1'b1);
        run_op(1'b1, 8'h13, 32'h11223344, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, "byte_store_13");
        run_op(1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, "word_after_byte");
    endtask
`endif

    initial begin
        test_reset();
        test_word_load();
        test_word_store();
        test_back_to_back();
        test_idle();
        test_reset_abort();
        test_random();
`ifdef MEM_BYTE_LSU_BYTE_ACCESS_EN
        test_byte_access();
`endif
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
